pc_unit: RTL and testbench

Parametrised program-counter block with a return-address stack (RAS). Generalises the plain 16-bit PC register (load-on-`Write`) into a unit that selects increment, jump-register, PC-relative branch or return as the next PC, and links return addresses on calls. Sits between the register file's `Data1` read port (jump target) and instruction fetch.

---
 rtl/pc_unit.sv | 105 ++++++++++
 tb/tb_pc_unit.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit.sv
// Program counter with next-PC select and a circular return-address stack.
// Calls link PC+STEP; returns pop the stack or fall back to Target when empty.
module pc_unit #(
  parameter int WIDTH     = 16,
  parameter int STEP      = 2,
  parameter int RESET_PC  = 0,
  parameter int RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Write,
  input  logic [1:0]       Mode,
  input  logic [WIDTH-1:0] Target,
  input  logic [WIDTH-1:0] Offset,
  input  logic             Push,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCNext,
  output logic [WIDTH-1:0] RetAddr,
  output logic             RASEmpty,
  output logic             RASFull,
  output logic             Overflow,
  output logic             Underflow
);

  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = $clog2(RAS_DEPTH + 1);
  localparam logic [PW-1:0] LAST  = PW'(RAS_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH = CW'(RAS_DEPTH);

  localparam logic [1:0] M_INC = 2'b00;
  localparam logic [1:0] M_JR  = 2'b01;
  localparam logic [1:0] M_BR  = 2'b10;
  localparam logic [1:0] M_RET = 2'b11;

  logic [WIDTH-1:0] ras [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [PW-1:0]    top_inc;
  logic [PW-1:0]    top_dec;
  logic [PW-1:0]    wr_idx;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] link;
  logic [WIDTH-1:0] top_val;
  logic             ret;
  logic             pop;

  assign link     = PC + WIDTH'(STEP);
  assign top_val  = ras[top];
  assign RASEmpty = (count == '0);
  assign RASFull  = (count == DEPTH);
  assign RetAddr  = RASEmpty ? '0 : top_val;

  assign ret = (Mode == M_RET);
  assign pop = ret && !RASEmpty;

  assign top_inc = (top == LAST) ? '0 : top + PW'(1);
  assign top_dec = (top == '0) ? LAST : top - PW'(1);

  // Pop+push replaces the top entry in place.
  assign wr_idx = pop ? top : top_inc;

  always_comb begin
    PCNext = link;
    unique case (Mode)
      M_INC: PCNext = link;
      M_JR:  PCNext = Target;
      M_BR:  PCNext = link + Offset;
      M_RET: PCNext = RASEmpty ? Target : top_val;
      default: PCNext = link;
    endcase
  end

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      PC        <= WIDTH'(RESET_PC);
      top       <= '0;
      count     <= '0;
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else if (Write) begin
      PC <= PCNext;
      if (ret && RASEmpty)
        Underflow <= 1'b1;
      if (Push && pop) begin
        top   <= top;
        count <= count;
      end else if (Push) begin
        top <= top_inc;
        if (RASFull)
          Overflow <= 1'b1;
        else
          count <= count + CW'(1);
      end else if (pop) begin
        top   <= top_dec;
        count <= count - CW'(1);
      end
    end
  end

  // Stack storage carries no reset; entries are unreadable while empty.
  always_ff @(posedge CLK) begin
    if (Write && Push && !Reset)
      ras[wr_idx] <= link;
  end

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios plus randomized traffic
// against a queue-based model of the PC and return-address stack.
module tb_pc_unit;

  logic        CLK = 1'b0;
  logic        Reset = 1'b0;
  logic        Write = 1'b0;
  logic [1:0]  Mode = 2'b00;
  logic [15:0] Target = '0;
  logic [15:0] Offset = '0;
  logic        Push = 1'b0;
  logic [15:0] PC;
  logic [15:0] PCNext;
  logic [15:0] RetAddr;
  logic        RASEmpty;
  logic        RASFull;
  logic        Overflow;
  logic        Underflow;

  pc_unit #(
    .WIDTH(16), .STEP(2), .RESET_PC(0), .RAS_DEPTH(4)
  ) dut (
    .CLK(CLK), .Reset(Reset), .Write(Write),
    .Mode(Mode), .Target(Target), .Offset(Offset),
    .Push(Push), .PC(PC), .PCNext(PCNext),
    .RetAddr(RetAddr), .RASEmpty(RASEmpty),
    .RASFull(RASFull), .Overflow(Overflow),
    .Underflow(Underflow)
  );

  always #5 CLK = ~CLK;

  int n_vec = 0;
  int n_err = 0;

  logic [15:0] m_pc;
  logic [15:0] ras_q[$];
  logic        m_ovf;
  logic        m_unf;

  function automatic logic [15:0] m_next();
    case (Mode)
      2'd0: return m_pc + 16'd2;
      2'd1: return Target;
      2'd2: return m_pc + 16'd2 + Offset;
      default:
        return (ras_q.size() > 0) ? ras_q[$] : Target;
    endcase
  endfunction

  function automatic logic [15:0] m_ret();
    return (ras_q.size() > 0) ? ras_q[$] : 16'h0000;
  endfunction

  function automatic logic [3:0] m_flags();
    return {ras_q.size() == 0, ras_q.size() == 4, m_ovf, m_unf};
  endfunction

  task automatic m_clock();
    logic [15:0] nx;
    logic [15:0] lk;
    if (!Write) return;
    nx = m_next();
    lk = m_pc + 16'd2;
    if (Mode == 2'd3 && ras_q.size() == 0) m_unf = 1'b1;
    if (Mode == 2'd3 && ras_q.size() > 0) begin
      if (Push) ras_q[ras_q.size()-1] = lk;
      else void'(ras_q.pop_back());
    end else if (Push) begin
      if (ras_q.size() == 4) begin
        void'(ras_q.pop_front());
        m_ovf = 1'b1;
      end
      ras_q.push_back(lk);
    end
    m_pc = nx;
  endtask

  task automatic m_reset();
    m_pc = 16'h0000;
    ras_q.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    if (!Reset) m_clock();
    #1;
  endtask

  task automatic step(input logic w, input logic [1:0] m,
                      input logic [15:0] t, input logic [15:0] o,
                      input logic p);
    Write = w; Mode = m; Target = t; Offset = o; Push = p;
    tick();
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    m_reset();
    #2;
    Reset = 1'b0;
  endtask

  logic [3:0] flg;

  task automatic test_reset();
    #1 Reset = 1'b1;
    m_reset();
    #1;
    flg = {RASEmpty, RASFull, Overflow, Underflow};
    n_vec++;
    if (PC !== 16'h0000 || RetAddr !== 16'h0000 || flg !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_init: PC=%h Ret=%h flags=%b exp 0000 0000 1000",
               PC, RetAddr, flg);
    end
    @(posedge CLK); #1;
    Reset = 1'b0;
    step(1, 2'd3, 16'h003E, 0, 0);
    step(1, 2'd0, 0, 0, 1);
    n_vec++;
    if (PC !== 16'h0040 || Underflow !== 1'b1 || RASEmpty !== 1'b0) begin
      n_err++;
      $display("FAIL reset_pre: PC=%h unf=%b emp=%b exp 0040 1 0",
               PC, Underflow, RASEmpty);
    end
    #2 Reset = 1'b1;
    m_reset();
    #1;
    flg = {RASEmpty, RASFull, Overflow, Underflow};
    n_vec++;
    if (PC !== 16'h0000 || RetAddr !== 16'h0000 || flg !== 4'b1000) begin
      n_err++;
      $display("FAIL reset_async: PC=%h Ret=%h flags=%b exp 0000 0000 1000",
               PC, RetAddr, flg);
    end
    Write = 1'b1; Mode = 2'd1; Target = 16'h0abc; Push = 1'b1;
    tick();
    tick();
    n_vec++;
    if (PC !== 16'h0000 || RASEmpty !== 1'b1) begin
      n_err++;
      $display("FAIL reset_hold: PC=%h emp=%b exp 0000 1", PC, RASEmpty);
    end
    Reset = 1'b0;
  endtask

  task automatic test_increment();
    logic [15:0] exp_inc [3];
    exp_inc = '{16'h0002, 16'h0004, 16'h0006};
    do_reset();
    for (int i = 0; i < 3; i++) begin
      step(1, 2'd0, 0, 0, 0);
      n_vec++;
      if (PC !== exp_inc[i]) begin
        n_err++;
        $display("FAIL inc_%0d: PC=%h exp %h", i, PC, exp_inc[i]);
      end
    end
    step(0, 2'd0, 0, 0, 1);
    step(0, 2'd3, 0, 0, 1);
    n_vec++;
    if (PC !== 16'h0006 || RASEmpty !== 1'b1) begin
      n_err++;
      $display("FAIL hold: PC=%h emp=%b exp 0006 1", PC, RASEmpty);
    end
    Mode = 2'd1; Target = 16'h1234;
    #1;
    n_vec++;
    if (PCNext !== 16'h1234 || PC !== 16'h0006) begin
      n_err++;
      $display("FAIL pcnext_hold: PCNext=%h PC=%h exp 1234 0006",
               PCNext, PC);
    end
    step(1, 2'd1, 16'hFFFE, 0, 0);
    step(1, 2'd0, 0, 0, 0);
    n_vec++;
    if (PC !== 16'h0000) begin
      n_err++;
      $display("FAIL wrap: PC=%h exp 0000", PC);
    end
  endtask

  task automatic test_jump_branch();
    do_reset();
    step(1, 2'd1, 16'h0008, 0, 0);
    n_vec++;
    if (PC !== 16'h0008) begin
      n_err++;
      $display("FAIL jr: PC=%h exp 0008", PC);
    end
    step(1, 2'd1, 16'h0010, 0, 0);
    step(1, 2'd2, 0, 16'hFFF8, 0);
    n_vec++;
    if (PC !== 16'h000A) begin
      n_err++;
      $display("FAIL br_neg: PC=%h exp 000a", PC);
    end
    step(1, 2'd2, 0, 16'h0004, 0);
    n_vec++;
    if (PC !== 16'h0010) begin
      n_err++;
      $display("FAIL br_pos: PC=%h exp 0010", PC);
    end
  endtask

  task automatic test_call_return();
    do_reset();
    step(1, 2'd1, 16'h0100, 0, 0);
    step(1, 2'd1, 16'h0200, 0, 1);
    n_vec++;
    if (PC !== 16'h0200 || RetAddr !== 16'h0102 || RASEmpty !== 1'b0) begin
      n_err++;
      $display("FAIL call: PC=%h Ret=%h emp=%b exp 0200 0102 0",
               PC, RetAddr, RASEmpty);
    end
    step(1, 2'd3, 16'h0777, 0, 0);
    n_vec++;
    if (PC !== 16'h0102 || RASEmpty !== 1'b1 || Underflow !== 1'b0) begin
      n_err++;
      $display("FAIL return: PC=%h emp=%b unf=%b exp 0102 1 0",
               PC, RASEmpty, Underflow);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] exp_ret [4];
    exp_ret = '{16'h0052, 16'h0042, 16'h0032, 16'h0022};
    do_reset();
    step(1, 2'd1, 16'h0010, 0, 0);
    for (int i = 0; i < 5; i++)
      step(1, 2'd1, 16'h0020 + 16'(i * 16), 0, 1);
    n_vec++;
    if (RASFull !== 1'b1 || Overflow !== 1'b1 || RetAddr !== 16'h0052) begin
      n_err++;
      $display("FAIL ovf: full=%b ovf=%b Ret=%h exp 1 1 0052",
               RASFull, Overflow, RetAddr);
    end
    for (int i = 0; i < 4; i++) begin
      step(1, 2'd3, 16'h0999, 0, 0);
      n_vec++;
      if (PC !== exp_ret[i]) begin
        n_err++;
        $display("FAIL ovf_ret_%0d: PC=%h exp %h", i, PC, exp_ret[i]);
      end
    end
    n_vec++;
    if (RASEmpty !== 1'b1 || Underflow !== 1'b0 || Overflow !== 1'b1) begin
      n_err++;
      $display("FAIL ovf_drain: emp=%b unf=%b ovf=%b exp 1 0 1",
               RASEmpty, Underflow, Overflow);
    end
  endtask

  task automatic test_underflow();
    do_reset();
    step(1, 2'd3, 16'h0300, 0, 0);
    n_vec++;
    if (PC !== 16'h0300 || Underflow !== 1'b1 || RASEmpty !== 1'b1) begin
      n_err++;
      $display("FAIL unf: PC=%h unf=%b emp=%b exp 0300 1 1",
               PC, Underflow, RASEmpty);
    end
    do_reset();
    step(1, 2'd1, 16'h0100, 0, 0);
    step(1, 2'd1, 16'h0400, 0, 1);
    step(1, 2'd3, 16'h0555, 0, 1);
    n_vec++;
    if (PC !== 16'h0102 || RetAddr !== 16'h0402 || Underflow !== 1'b0) begin
      n_err++;
      $display("FAIL ret_push: PC=%h Ret=%h unf=%b exp 0102 0402 0",
               PC, RetAddr, Underflow);
    end
    step(1, 2'd3, 16'h0555, 0, 0);
    n_vec++;
    if (PC !== 16'h0402 || RASEmpty !== 1'b1) begin
      n_err++;
      $display("FAIL ret_push_cnt: PC=%h emp=%b exp 0402 1", PC, RASEmpty);
    end
    step(1, 2'd3, 16'h0660, 0, 1);
    n_vec++;
    if (PC !== 16'h0660 || RetAddr !== 16'h0404 ||
        Underflow !== 1'b1 || RASEmpty !== 1'b0) begin
      n_err++;
      $display("FAIL empty_ret_push: PC=%h Ret=%h unf=%b emp=%b exp 0660 0404 1 0",
               PC, RetAddr, Underflow, RASEmpty);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(59) == 0) begin
        Reset = 1'b1;
        m_reset();
        #1;
        n_vec++;
        if (PC !== 16'h0000 || RASEmpty !== 1'b1) begin
          n_err++;
          $display("FAIL rnd_reset_%0d: PC=%h emp=%b exp 0000 1",
                   i, PC, RASEmpty);
        end
        #1 Reset = 1'b0;
      end
      Write  = ($urandom_range(3) != 0);
      Mode   = 2'($urandom_range(3));
      Target = 16'($urandom);
      Offset = 16'($urandom);
      Push   = ($urandom_range(2) == 0);
      #1;
      n_vec++;
      if (PCNext !== m_next()) begin
        n_err++;
        $display("FAIL rnd_pcnext_%0d: PCNext=%h exp %h",
                 i, PCNext, m_next());
      end
      tick();
      flg = {RASEmpty, RASFull, Overflow, Underflow};
      n_vec++;
      if (PC !== m_pc || RetAddr !== m_ret() || flg !== m_flags()) begin
        n_err++;
        $display("FAIL rnd_state_%0d: PC=%h Ret=%h flags=%b exp %h %h %b",
                 i, PC, RetAddr, flg, m_pc, m_ret(), m_flags());
      end
    end
  endtask

  initial begin
    m_reset();
    test_reset();
    test_increment();
    test_jump_branch();
    test_call_return();
    test_overflow();
    test_underflow();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
